funct_generator_amp_ctrl: RTL and testbench

- Controller and arbiter for the function generator's 8-bit amplitude register.
- Shares write access among three requesters, in fixed priority: clear, host write (immediate or slewed ramp), and up/down step pulses from the front panel.
- Drives the register's clrh/enh/d inputs and keeps a shadow copy of the amplitude.
- Sits between the command/panel logic and the amplitude register, in the same clock domain.

---
 rtl/funct_generator_pkg.sv | 18 +
 rtl/funct_generator_ramp_timer.sv | 28 ++
 rtl/funct_generator_amp_ctrl.sv | 173 +++++++++++++++++
 tb/tb_funct_generator_amp_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/funct_generator_pkg.sv
// Shared types and helpers for the function generator amplitude path.
package funct_generator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      RAMP  = 2'd2
   } amp_ctrl_state_e;

   function automatic logic [31:0] clamp_amp(input logic [31:0] value,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
      if (value < lo) return lo;
      if (value > hi) return hi;
      return value;
   endfunction

endpackage

// File: rtl/funct_generator_ramp_timer.sv
// Free-running 0..RAMP_DIV-1 divider for ramp pacing; tick is high in the wrap cycle.
// Synchronous clear has priority over enable; counting only while enabled.
module funct_generator_ramp_timer #(
   parameter int RAMP_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/funct_generator_amp_ctrl.sv
// Arbitrates clear / host write or ramp / panel steps onto the amplitude register.
// All outputs registered; host writes ack one cycle after sampling, ramps ack on arrival.
module funct_generator_amp_ctrl #(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 8'h10,
   parameter logic [DATA_WIDTH-1:0] AMP_MIN     = 8'h00,
   parameter logic [DATA_WIDTH-1:0] AMP_MAX     = 8'hFF,
   parameter logic [DATA_WIDTH-1:0] STEP        = 8'h01,
   parameter int                    RAMP_DIV    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   input  logic                  host_req,
   input  logic [DATA_WIDTH-1:0] host_val,
   input  logic                  host_ramp,
   output logic                  host_ack,
   input  logic                  inc_p,
   input  logic                  dec_p,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] amp_q,
   output logic                  reg_enh,
   output logic                  reg_clrh,
   output logic [DATA_WIDTH-1:0] reg_d
);

   import funct_generator_pkg::*;

   localparam logic [DATA_WIDTH:0] DEC_FLOOR = {1'b0, AMP_MIN} + {1'b0, STEP};

   amp_ctrl_state_e       state, state_n;
   logic [DATA_WIDTH-1:0] amp_n, reg_d_n, target, target_n;
   logic [DATA_WIDTH-1:0] host_clamped, inc_val, dec_val, ramp_val;
   logic [DATA_WIDTH:0]   up_sum;
   logic                  enh_n, clrh_n, ack_n, ramp_start, tick;
   logic                  inc_pend, dec_pend, inc_n, dec_n;

   funct_generator_ramp_timer #(.RAMP_DIV(RAMP_DIV)) u_ramp_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (ramp_start),
      .en   (state == RAMP),
      .tick (tick)
   );

   // Step arithmetic is one bit wider so saturation never sees a wrapped value.
   assign up_sum       = {1'b0, amp_q} + {1'b0, STEP};
   assign host_clamped = DATA_WIDTH'(clamp_amp(32'(host_val), 32'(AMP_MIN), 32'(AMP_MAX)));
   assign inc_val      = (up_sum > {1'b0, AMP_MAX}) ? AMP_MAX : up_sum[DATA_WIDTH-1:0];
   assign dec_val      = ({1'b0, amp_q} >= DEC_FLOOR) ? amp_q - STEP : AMP_MIN;

   always_comb begin
      ramp_val = target;
      if (target > amp_q) begin
         if (up_sum < {1'b0, target}) ramp_val = up_sum[DATA_WIDTH-1:0];
      end else if ({1'b0, amp_q} > {1'b0, target} + {1'b0, STEP}) begin
         ramp_val = amp_q - STEP;
      end
   end

   always_comb begin
      state_n    = state;
      amp_n      = amp_q;
      reg_d_n    = reg_d;
      target_n   = target;
      enh_n      = 1'b0;
      clrh_n     = 1'b0;
      ack_n      = 1'b0;
      ramp_start = 1'b0;
      inc_n      = inc_pend;
      dec_n      = dec_pend;
      case (state)
         IDLE: begin
            if (clr_req) begin
               clrh_n = 1'b1;
               amp_n  = RESET_VALUE;
               inc_n  = 1'b0;
               dec_n  = 1'b0;
            end else begin
               if (host_req && !host_ramp) begin
                  reg_d_n = host_clamped;
                  amp_n   = host_clamped;
                  enh_n   = 1'b1;
                  ack_n   = 1'b1;
                  state_n = WRITE;
               end else if (host_req) begin
                  target_n   = host_clamped;
                  ramp_start = 1'b1;
                  state_n    = RAMP;
               end else if (inc_pend && dec_pend) begin
                  inc_n = 1'b0;
                  dec_n = 1'b0;
               end else if (inc_pend) begin
                  inc_n = 1'b0;
                  if (inc_val != amp_q) begin
                     enh_n   = 1'b1;
                     reg_d_n = inc_val;
                     amp_n   = inc_val;
                  end
               end else if (dec_pend) begin
                  dec_n = 1'b0;
                  if (dec_val != amp_q) begin
                     enh_n   = 1'b1;
                     reg_d_n = dec_val;
                     amp_n   = dec_val;
                  end
               end
               inc_n = inc_n | inc_p;
               dec_n = dec_n | dec_p;
            end
         end
         WRITE: begin
            state_n = IDLE;
            if (clr_req) begin
               clrh_n = 1'b1;
               amp_n  = RESET_VALUE;
               inc_n  = 1'b0;
               dec_n  = 1'b0;
            end else begin
               inc_n = inc_pend | inc_p;
               dec_n = dec_pend | dec_p;
            end
         end
         RAMP: begin
            if (clr_req) begin
               clrh_n  = 1'b1;
               amp_n   = RESET_VALUE;
               ack_n   = 1'b1;
               state_n = IDLE;
            end else if (amp_q == target) begin
               ack_n   = 1'b1;
               state_n = IDLE;
            end else if (tick) begin
               enh_n   = 1'b1;
               reg_d_n = ramp_val;
               amp_n   = ramp_val;
               if (ramp_val == target) begin
                  ack_n   = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         amp_q    <= RESET_VALUE;
         reg_d    <= RESET_VALUE;
         target   <= RESET_VALUE;
         reg_clrh <= 1'b1;
         reg_enh  <= 1'b0;
         host_ack <= 1'b0;
         busy     <= 1'b0;
         inc_pend <= 1'b0;
         dec_pend <= 1'b0;
      end else begin
         state    <= state_n;
         amp_q    <= amp_n;
         reg_d    <= reg_d_n;
         target   <= target_n;
         reg_clrh <= clrh_n;
         reg_enh  <= enh_n;
         host_ack <= ack_n;
         busy     <= (state_n == RAMP);
         inc_pend <= inc_n;
         dec_pend <= dec_n;
      end
   end

endmodule

// File: tb/tb_funct_generator_amp_ctrl.sv
// Randomized self-checking bench for funct_generator_amp_ctrl against a behavioural amplitude model.
module tb_funct_generator_amp_ctrl;

   localparam int RD   = 4;
   localparam int ST   = 1;
   localparam int RSTV = 'h10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr_req = 1'b0, host_req = 1'b0, host_ramp = 1'b0, inc_p = 1'b0, dec_p = 1'b0;
   logic [7:0] host_val = 8'h00;
   logic       host_ack, busy, reg_enh, reg_clrh;
   logic [7:0] amp_q, reg_d;

   int errors = 0;
   int checks = 0;
   int model_amp;

   funct_generator_amp_ctrl #(.RAMP_DIV(RD)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr_req   (clr_req),
      .host_req  (host_req),
      .host_val  (host_val),
      .host_ramp (host_ramp),
      .host_ack  (host_ack),
      .inc_p     (inc_p),
      .dec_p     (dec_p),
      .busy      (busy),
      .amp_q     (amp_q),
      .reg_enh   (reg_enh),
      .reg_clrh  (reg_clrh),
      .reg_d     (reg_d)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_up(input int a);
      return (a + ST > 255) ? 255 : a + ST;
   endfunction

   function automatic int ref_dn(input int a);
      return (a - ST < 0) ? 0 : a - ST;
   endfunction

   task automatic set_amp(input int v);
      host_req = 1'b1; host_ramp = 1'b0; host_val = 8'(v);
      step();
      host_req = 1'b0;
      step();
      model_amp = v;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      checks++; if (reg_clrh !== 1'b1) begin errors++; $display("FAIL rst_clrh: got %b want 1", reg_clrh); end
      checks++; if (amp_q !== 8'h10) begin errors++; $display("FAIL rst_amp: got %h want 10", amp_q); end
      checks++; if (reg_d !== 8'h10) begin errors++; $display("FAIL rst_d: got %h want 10", reg_d); end
      checks++; if (busy !== 1'b0 || host_ack !== 1'b0 || reg_enh !== 1'b0) begin
         errors++; $display("FAIL rst_flags: busy=%b ack=%b enh=%b want 0", busy, host_ack, reg_enh); end
      step();
      checks++; if (reg_clrh !== 1'b0) begin errors++; $display("FAIL rst_clrh_once: got %b want 0", reg_clrh); end
      model_amp = RSTV;
   endtask

   task automatic test_host_write();
      logic [7:0] v;
      for (int i = 0; i < 6; i++) begin
         v = (i == 0) ? 8'h80 : 8'($urandom_range(0, 255));
         host_req = 1'b1; host_ramp = 1'b0; host_val = v;
         step();
         checks++; if (reg_enh !== 1'b1 || host_ack !== 1'b1) begin
            errors++; $display("FAIL hw_pulse: enh=%b ack=%b want 1/1", reg_enh, host_ack); end
         checks++; if (reg_d !== v || amp_q !== v) begin
            errors++; $display("FAIL hw_data: d=%h amp=%h want %h", reg_d, amp_q, v); end
         host_req = 1'b0;
         step();
         checks++; if (reg_enh !== 1'b0 || host_ack !== 1'b0) begin
            errors++; $display("FAIL hw_single: enh=%b ack=%b want 0/0", reg_enh, host_ack); end
         step();
         checks++; if (reg_enh !== 1'b0 || amp_q !== v) begin
            errors++; $display("FAIL hw_hold: enh=%b amp=%h want 0/%h", reg_enh, amp_q, v); end
         model_amp = v;
      end
   endtask

   task automatic test_steps();
      int n, k, e;
      for (int p = 0; p < 3; p++) begin
         if (p == 0) set_amp('hFE);
         else if (p == 1) set_amp('h01);
         else set_amp($urandom_range(0, 255));
         n = (p == 2) ? 10 : 3;
         for (int i = 0; i < n; i++) begin
            k = (p == 0) ? 0 : (p == 1) ? 1 : int'($urandom_range(0, 1));
            e = (k == 0) ? ref_up(model_amp) : ref_dn(model_amp);
            inc_p = (k == 0); dec_p = (k == 1);
            step();
            inc_p = 1'b0; dec_p = 1'b0;
            checks++; if (reg_enh !== 1'b0) begin errors++; $display("FAIL step_early: enh=%b want 0", reg_enh); end
            step();
            checks++; if (reg_enh !== (e != model_amp)) begin
               errors++; $display("FAIL step_enh: enh=%b want %b (amp %h)", reg_enh, (e != model_amp), model_amp); end
            checks++; if (amp_q !== 8'(e) || (e != model_amp && reg_d !== 8'(e))) begin
               errors++; $display("FAIL step_val: amp=%h d=%h want %h", amp_q, reg_d, 8'(e)); end
            model_amp = e;
         end
      end
      inc_p = 1'b1; dec_p = 1'b1;
      step();
      inc_p = 1'b0; dec_p = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (reg_enh !== 1'b0 || amp_q !== 8'(model_amp)) begin
            errors++; $display("FAIL step_both: enh=%b amp=%h want 0/%h", reg_enh, amp_q, 8'(model_amp)); end
      end
   endtask

   task automatic run_ramp(input int t, input int clr_k);
      int a, n, dir, ack_k, end_k, prog, fin;
      bit do_clr, hit;
      logic [7:0] ev;
      a = model_amp;
      n = (t > a) ? t - a : a - t;
      dir = (t > a) ? 1 : -1;
      ack_k = (n == 0) ? 1 : RD * ((n + ST - 1) / ST);
      do_clr = (clr_k > 0) && (clr_k <= ack_k);
      end_k = do_clr ? clr_k : ack_k;
      fin = do_clr ? RSTV : t;
      host_req = 1'b1; host_ramp = 1'b1; host_val = 8'(t);
      step();
      host_req = 1'b0; host_ramp = 1'b0;
      checks++; if (busy !== 1'b1 || reg_enh !== 1'b0 || host_ack !== 1'b0) begin
         errors++; $display("FAIL ramp_entry: busy=%b enh=%b ack=%b want 1/0/0", busy, reg_enh, host_ack); end
      for (int k = 1; k <= end_k + 3; k++) begin
         if (k == 2 && end_k > 2) inc_p = 1'b1;
         if (do_clr && k == clr_k) clr_req = 1'b1;
         step();
         inc_p = 1'b0; clr_req = 1'b0;
         if (do_clr && k == clr_k) begin
            checks++; if (reg_clrh !== 1'b1 || host_ack !== 1'b1 || busy !== 1'b0 || reg_enh !== 1'b0) begin
               errors++; $display("FAIL ramp_abort k=%0d: clrh=%b ack=%b busy=%b enh=%b want 1/1/0/0", k, reg_clrh, host_ack, busy, reg_enh); end
            checks++; if (amp_q !== 8'(RSTV)) begin errors++; $display("FAIL ramp_abort_amp: got %h want 10", amp_q); end
         end else if (k > end_k) begin
            checks++; if (reg_enh !== 1'b0 || host_ack !== 1'b0 || busy !== 1'b0 || amp_q !== 8'(fin)) begin
               errors++; $display("FAIL ramp_after k=%0d: enh=%b ack=%b busy=%b amp=%h want 0/0/0/%h", k, reg_enh, host_ack, busy, amp_q, 8'(fin)); end
         end else begin
            hit  = (n > 0) && (k % RD == 0);
            prog = ST * (k / RD);
            if (prog > n) prog = n;
            ev = 8'(a + dir * prog);
            checks++; if (reg_enh !== hit || amp_q !== ev || (hit && reg_d !== ev)) begin
               errors++; $display("FAIL ramp_step k=%0d: enh=%b amp=%h d=%h want %b/%h", k, reg_enh, amp_q, reg_d, hit, ev); end
            checks++; if (host_ack !== (k == ack_k) || busy !== (k < ack_k) || reg_clrh !== 1'b0) begin
               errors++; $display("FAIL ramp_hs k=%0d: ack=%b busy=%b clrh=%b want %b/%b/0", k, host_ack, busy, reg_clrh, (k == ack_k), (k < ack_k)); end
         end
      end
      model_amp = fin;
   endtask

   task automatic test_ramp();
      int t;
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      checks++; if (reg_clrh !== 1'b1 || amp_q !== 8'h10 || reg_enh !== 1'b0) begin
         errors++; $display("FAIL idle_clr: clrh=%b amp=%h enh=%b want 1/10/0", reg_clrh, amp_q, reg_enh); end
      model_amp = RSTV;
      run_ramp('h14, 0);
      run_ramp(model_amp, 0);
      for (int i = 0; i < 5; i++) begin
         t = model_amp + int'($urandom_range(0, 12)) - 6;
         if (t < 0) t = 0;
         if (t > 255) t = 255;
         run_ramp(t, 0);
      end
   endtask

   task automatic test_ramp_clear();
      set_amp(RSTV);
      run_ramp('h40, 2 * RD + 1);
      set_amp($urandom_range(0, 255));
      run_ramp(model_amp + ((model_amp > 128) ? -5 : 5), RD * int'($urandom_range(1, 4)));
   endtask

   task automatic test_clr_vs_host();
      set_amp('h55);
      clr_req = 1'b1; host_req = 1'b1; host_ramp = 1'b0; host_val = 8'h33;
      step();
      clr_req = 1'b0;
      checks++; if (reg_clrh !== 1'b1 || reg_enh !== 1'b0 || host_ack !== 1'b0 || amp_q !== 8'h10) begin
         errors++; $display("FAIL clr_wins: clrh=%b enh=%b ack=%b amp=%h want 1/0/0/10", reg_clrh, reg_enh, host_ack, amp_q); end
      step();
      host_req = 1'b0;
      checks++; if (reg_enh !== 1'b1 || host_ack !== 1'b1 || reg_d !== 8'h33 || amp_q !== 8'h33) begin
         errors++; $display("FAIL host_after_clr: enh=%b ack=%b d=%h amp=%h want 1/1/33/33", reg_enh, host_ack, reg_d, amp_q); end
      step();
      model_amp = 'h33;
   endtask

   task automatic test_reset_mid_ramp();
      set_amp(RSTV);
      host_req = 1'b1; host_ramp = 1'b1; host_val = 8'h40;
      step();
      host_req = 1'b0; host_ramp = 1'b0;
      repeat (6) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      checks++; if (busy !== 1'b0 || host_ack !== 1'b0 || amp_q !== 8'h10 || reg_clrh !== 1'b1) begin
         errors++; $display("FAIL rst_ramp: busy=%b ack=%b amp=%h clrh=%b want 0/0/10/1", busy, host_ack, amp_q, reg_clrh); end
      for (int i = 0; i < 2 * RD; i++) begin
         step();
         checks++; if (host_ack !== 1'b0 || reg_enh !== 1'b0 || busy !== 1'b0 || amp_q !== 8'h10) begin
            errors++; $display("FAIL rst_ramp_quiet: ack=%b enh=%b busy=%b amp=%h want 0/0/0/10", host_ack, reg_enh, busy, amp_q); end
      end
      model_amp = RSTV;
   endtask

   initial begin
      test_reset();
      test_host_write();
      test_steps();
      test_ramp();
      test_ramp_clear();
      test_clr_vs_host();
      test_reset_mid_ramp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
